// File: rtl/mealy_sched_pkg.sv
// Shared definitions for the Mealy sequence-detector scheduler:
// FSM state encoding, default parameter values and the width helper.
package mealy_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int N_REQ_DEFAULT = 4;
    localparam int W_DEFAULT     = 8;

    // Bits needed to encode n distinct values, never less than one.
    function automatic int sched_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mealy_seq_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request
// at or above the pointer, wrapping, and reports it one-hot and as an index.
module rr_arbiter
    import mealy_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int ID_W  = sched_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    // Scan N_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        int pos;
        pos = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!any && req[pos]) begin
                any      = 1'b1;
                idx      = ID_W'(pos);
                gnt[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mealy_seq_scheduler.sv
// Shares one external Mealy sequence detector between N_REQ requesters.
// Each transaction: round-robin grant, one detector clear cycle, W bits
// shifted MSB-first onto det_x, then a done pulse with the z-pulse count.
// Optional feature macro: MEALY_SCHED_ABORT_EN adds abort/aborted ports that
// cut a transaction short and report the partial count.
module mealy_seq_scheduler
    import mealy_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int W     = W_DEFAULT,
    parameter int CNT_W = sched_width(W + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*W-1:0]        req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(N_REQ)-1:0]  done_id,
    output logic [CNT_W-1:0]          match_cnt,
    output logic                      det_x,
    output logic                      det_clr,
`ifdef MEALY_SCHED_ABORT_EN
    input  logic                      abort,
    output logic                      aborted,
`endif
    input  logic                      det_z
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int BC_W = sched_width(W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(W - 1);
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_REQ - 1);

    sched_state_t state, state_next;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  arb_idx;
    logic [N_REQ-1:0] arb_gnt;
    logic             arb_any;
    logic [W-1:0]     shreg;
    logic [BC_W-1:0]  bit_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_final;
    logic             finish;
    logic             abort_now;

`ifdef MEALY_SCHED_ABORT_EN
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    // z only counts while a word bit is on det_x; includes this cycle's z.
    assign cnt_final = cnt + CNT_W'((state == SHIFT) && det_z);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // State register; reset aborts any transaction without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Mealy outputs; gnt is masked while reset is held.
    always_comb begin
        state_next = state;
        gnt        = '0;
        busy       = 1'b0;
        done       = 1'b0;
        det_clr    = 1'b0;
        det_x      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any && reset) begin
                    gnt        = arb_gnt;
                    busy       = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                busy       = 1'b1;
                det_clr    = 1'b1;
                state_next = SHIFT;
                if (abort_now) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                det_x = shreg[W-1];
                if ((bit_cnt == LAST_BIT) || abort_now) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word datapath: load on the grant cycle, shift and count during SHIFT.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            cur_id  <= arb_idx;
            shreg   <= req_data[arb_idx*W +: W];
            bit_cnt <= '0;
            cnt     <= '0;
        end else if (state == SHIFT) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
            cnt     <= cnt_final;
        end
    end

    // Pointer advances past each grantee; results latch as DONE is entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            done_id   <= '0;
            match_cnt <= '0;
`ifdef MEALY_SCHED_ABORT_EN
            aborted   <= 1'b0;
`endif
        end else begin
            if (gnt != '0) begin
                rr_ptr <= (arb_idx == LAST_ID) ? '0 : arb_idx + 1'b1;
            end
            if (finish) begin
                done_id   <= cur_id;
                match_cnt <= cnt_final;
`ifdef MEALY_SCHED_ABORT_EN
                aborted   <= abort_now;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mealy_seq_scheduler.sv
// Scoreboard bench for mealy_seq_scheduler with an overlapping "101"
// detector model. Directed tests push expected results; a negedge monitor
// pops and compares on every done pulse.
module tb_mealy_seq_scheduler;

    localparam int N_REQ = 4;
    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int ID_W  = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [N_REQ-1:0]   req = '0;
    logic [N_REQ*W-1:0] req_data = '0;
    logic [N_REQ-1:0]   gnt;
    logic               busy, done, det_x, det_clr, det_z;
    logic [ID_W-1:0]    done_id;
    logic [CNT_W-1:0]   match_cnt;
`ifdef MEALY_SCHED_ABORT_EN
    logic               abort = 1'b0;
    logic               aborted;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt2_cnt = 0;
    logic [1:0] hist;

    typedef struct {
        int id;
        int cnt;
        bit ab;
    } exp_t;
    exp_t sb[$];
    int   done_cyc[$];

    mealy_seq_scheduler #(.N_REQ(N_REQ), .W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt),
        .det_x     (det_x),
        .det_clr   (det_clr),
`ifdef MEALY_SCHED_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .det_z     (det_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Detector model: z when x=1 and the previous two bits were 1 then 0.
    assign det_z = det_x & hist[1] & ~hist[0];
    always @(posedge clk or negedge reset) begin
        if (!reset)       hist <= 2'b00;
        else if (det_clr) hist <= 2'b00;
        else              hist <= {hist[0], det_x};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input int cnt, input bit ab);
        exp_t e;
        e.id  = id;
        e.cnt = cnt;
        e.ab  = ab;
        sb.push_back(e);
    endtask

    // Monitor: compare every done against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (gnt[2]) gnt2_cnt++;
            if (done) begin
                exp_t e;
                done_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got id %0d cnt %0d with nothing expected", done_id, match_cnt);
                end else begin
                    e = sb.pop_front();
                    chk("done_id", int'(done_id), e.id);
                    chk("match_cnt", int'(match_cnt), e.cnt);
`ifdef MEALY_SCHED_ABORT_EN
                    chk("aborted", int'(aborted), int'(e.ab));
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_gnt(input string name, input logic [N_REQ-1:0] exp_g);
        int n;
        n = 0;
        @(negedge clk);
        while (gnt == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(gnt), int'(exp_g));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(busy) * 100 + sb.size(), 0);
    endtask

    task automatic run_one(input int id, input logic [W-1:0] data, input int cnt);
        tick();
        push_exp(id, cnt, 1'b0);
        req_data[id*W +: W] = data;
        req = 4'b0001 << id;
        wait_gnt("run_gnt", 4'b0001 << id);
        tick();
        req = '0;
        wait_idle("run_idle");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] pat;

        // Reset state, with every request asserted.
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_det_x", int'(det_x), 0);
        chk("rst_det_clr", int'(det_clr), 0);
        chk("rst_done_id", int'(done_id), 0);
        chk("rst_match_cnt", int'(match_cnt), 0);

        // Test 1: 0xAA on requester 0, cycle-accurate detector interface.
        do_reset();
        pat = 8'hAA;
        push_exp(0, 3, 1'b0);
        req_data[0 +: W] = pat;
        req = 4'b0001;
        @(negedge clk);
        chk("t1_gnt", int'(gnt), 1);
        chk("t1_busy", int'(busy), 1);
        tick();
        req = '0;
        @(negedge clk);
        chk("t1_det_clr", int'(det_clr), 1);
        chk("t1_clr_x", int'(det_x), 0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("t1_det_x", int'(det_x), int'(pat[W-1-i]));
            chk("t1_no_clr", int'(det_clr), 0);
        end
        @(negedge clk);
        chk("t1_done", int'(done), 1);
        @(negedge clk);
        chk("t1_busy_low", int'(busy), 0);

        // Test 2: the clear isolates consecutive words.
        run_one(0, 8'h02, 0);
        run_one(1, 8'h80, 0);

        // Test 3: all four hold req; round-robin order and done spacing.
        do_reset();
        done_cyc.delete();
        for (int k = 0; k < 5; k++) push_exp(k % 4, 3, 1'b0);
        req_data = {4{8'hB5}};
        req = 4'b1111;
        begin
            int ng, tries;
            ng = 0;
            tries = 0;
            while (ng < 5 && tries < 100) begin
                @(negedge clk);
                tries++;
                if (gnt != '0) begin
                    chk("t3_order", int'(gnt), 1 << (ng % 4));
                    ng++;
                end
            end
            chk("t3_grant_count", ng, 5);
        end
        tick();
        req = '0;
        wait_idle("t3_idle");
        chk("t3_done_count", done_cyc.size(), 5);
        for (int i = 1; i < done_cyc.size(); i++) begin
            chk("t3_done_spacing", done_cyc[i] - done_cyc[i-1], 11);
        end

        // Test 4: reset mid-transaction, then requester 1 pending.
        do_reset();
        req_data[0 +: W] = 8'hFF;
        req = 4'b0001;
        wait_gnt("t4_gnt0", 4'b0001);
        tick();
        req = 4'b0010;
        req_data[W +: W] = 8'hAA;
        repeat (4) tick();
        chk("t4_pre_busy", int'(busy), 1);
        chk("t4_pre_x", int'(det_x), 1);
        reset = 1'b0;
        #1;
        chk("t4_gnt", int'(gnt), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_done", int'(done), 0);
        chk("t4_det_x", int'(det_x), 0);
        chk("t4_det_clr", int'(det_clr), 0);
        chk("t4_done_id", int'(done_id), 0);
        chk("t4_match_cnt", int'(match_cnt), 0);
        push_exp(1, 3, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        wait_gnt("t4_gnt1", 4'b0010);
        tick();
        req = '0;
        wait_idle("t4_idle");

        // Test 5: a one-cycle request while busy is never granted.
        do_reset();
        gnt2_cnt = 0;
        push_exp(3, 0, 1'b0);
        req_data[3*W +: W] = 8'hF0;
        req = 4'b1000;
        wait_gnt("t5_gnt3", 4'b1000);
        tick();
        req = '0;
        tick();
        tick();
        req = 4'b0100;
        req_data[2*W +: W] = 8'hFF;
        tick();
        req = '0;
        wait_idle("t5_idle");
        repeat (3) @(negedge clk);
        chk("t5_req2_grants", gnt2_cnt, 0);

`ifdef MEALY_SCHED_ABORT_EN
        // Test 6: abort on the 5th bit reports the partial count.
        do_reset();
        push_exp(0, 2, 1'b1);
        req_data[0 +: W] = 8'hAA;
        req = 4'b0001;
        wait_gnt("t6_gnt", 4'b0001);
        tick();
        req = '0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("t6_done", int'(done), 1);
        wait_idle("t6_idle");
        run_one(1, 8'hAA, 3);
`endif

        chk("final_scoreboard", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mealy_seq_scheduler.md
Name: mealy_seq_scheduler

Overview:
- Shares one external Mealy sequence detector (inputs x/clk/reset, output z) between N_REQ requesters.
- Per transaction: grants one requester round-robin, clears the detector, and serialises the requester's W-bit word MSB-first onto the detector's x input.
- Counts z pulses during the word and returns the match count tagged with the requester id.
- Sits between the requester logic and the detector instance.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- W, 8, bits per word shifted into the detector
- CNT_W, $clog2(W+1), width of the match count

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  request per requester; hold until granted
- req_data  in  N_REQ*W  word per requester; slice i = bits [i*W +: W]
- gnt  out  N_REQ  one-hot, one-cycle grant pulse; data captured this cycle
- busy  out  1  high from grant cycle through done cycle
- done  out  1  one-cycle completion pulse
- done_id  out  $clog2(N_REQ)  requester index of completed word; held until next done
- match_cnt  out  CNT_W  z count of completed word; held until next done
- det_x  out  1  serial bit to detector x
- det_clr  out  1  synchronous clear to detector, high one cycle
- det_z  in  1  detector z (combinational Mealy output of det_x and detector state)

Behaviour:
- Reset (reset=0, async): state IDLE; rr pointer 0; all outputs 0.
- State IDLE:
  - No req: stay.
  - Otherwise select the first asserted req scanning from the rr pointer upward, wrapping.
  - Pulse gnt[sel]; capture req_data slice into the shift register; zero the bit counter and match counter; set busy; go to CLEAR.
  - rr pointer <= (sel+1) mod N_REQ.
- State CLEAR: det_clr=1 and det_x=0 for exactly one cycle; go to SHIFT.
- State SHIFT: W cycles.
  - det_x = shreg[W-1] (registered output, valid for the whole cycle).
  - When det_z=1 in a SHIFT cycle, match counter increments at the clock edge.
  - Shift left each cycle.
  - After the W-th bit, go to DONE.
- State DONE: done=1; done_id and match_cnt are updated this cycle; busy=1; det_x=0; next state IDLE.
- Latency:
  - grant at cycle 0, clear at 1, bits at 2..W+1, done at W+2.
  - Next grant is no earlier than W+3.
  - busy falls in IDLE.
- det_z is ignored outside SHIFT.
- The match counter cannot overflow: CNT_W holds W.
- req dropped before grant: no grant to that requester. req changing during a transaction has no effect on it (data already captured).
- A requester holding req after its done is re-arbitrated normally. The rr pointer guarantees every other pending requester is served first.
- reset asserted mid-transaction: immediate abort to IDLE; no done; det_x=0 and det_clr=0.

Optional Feature:
- Macro: MEALY_SCHED_ABORT_EN.
- When defined:
  - Adds input abort (1 bit) and output aborted (1 bit, valid with done, held like done_id).
  - abort=1 in CLEAR or SHIFT goes to DONE next cycle with aborted=1 and match_cnt = partial count, including the z of the current SHIFT cycle.
  - abort is ignored in IDLE and DONE. A normal done sets aborted=0.
- When undefined: ports absent; behaviour as above.

Decomposition:
- Package mealy_sched_pkg holds:
  - state enum {IDLE, CLEAR, SHIFT, DONE}
  - default parameter constants
  - the CNT_W/id-width helper function
- Sub-module rr_arbiter (N_REQ): req, pointer -> one-hot grant + index, purely combinational.
- The scheduler owns the pointer register.

Test Plan:
The bench's detector model asserts z when x=1 and the previous two bits were 1,0 (overlapping "101"); det_clr clears its history.
1. req=0001, data0=8'hAA -> gnt=0001 at cycle 0, det_clr at 1, det_x 1,0,1,0,1,0,1,0 at 2..9, done at 10 with done_id=0, match_cnt=3.
2. req=0001 data0=8'h02, then req=0010 data1=8'h80 -> both match_cnt=0, proving det_clr prevents cross-word matching.
3. req=1111 held continuously, all data=8'hB5 -> grants 0,1,2,3,0 in order, each match_cnt=3, done spacing 11 cycles.
4. reset=0 at cycle 5 of a transaction -> all outputs 0 immediately, no done; after release, pending req1 is granted first (pointer reset to 0, req0 idle).
5. req2 asserted for one cycle while busy, then dropped -> never granted. data3=8'hF0 -> match_cnt=0.
6. MEALY_SCHED_ABORT_EN: data=8'hAA, abort at the 5th bit cycle -> done next cycle, aborted=1, match_cnt=2.
